mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Synthesizable single-port memory responder: the target end of the RV32I multicycle core's memory bus (mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable in; mem_rdata/mem_resp out).
- Serves instruction fetches, loads and stores with a fixed, parameterized response latency. A backing word array is mapped at BASE_ADDR.
- Includes a preload port so benches and the top level can load a program before the core runs.

Parameters:
- DEPTH_LOG2, 10, log2 of array depth in 32-bit words; 1024 words by default.
- LATENCY, 3, cycles from request acceptance to mem_resp; must be at least 1.
- BASE_ADDR, 32'h40000000, byte address of word 0; equals the core's PC reset value.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- mem_read  in  1  read request, held until mem_resp
- mem_write  in  1  write request, held until mem_resp
- mem_byte_enable  in  4  write byte lanes; bit i enables byte i of mem_wdata
- mem_address  in  32  byte address, held stable until mem_resp
- mem_wdata  in  32  write data, held stable until mem_resp
- mem_rdata  out  32  read data, valid in the mem_resp cycle
- mem_resp  out  1  one-cycle completion pulse
- mem_err  out  1  one-cycle pulse coincident with mem_resp on an error
- init_we  in  1  preload write strobe
- init_addr  in  DEPTH_LOG2  preload word index
- init_data  in  32  preload word

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM returns to IDLE and the counter clears.
  - mem_resp=0, mem_err=0, mem_rdata=0.
  - Array contents are not cleared.
  - Reset during WAIT or RESP abandons the transaction. No write is performed and no mem_resp is produced.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: samples mem_read|mem_write at the clock edge. If set, it latches address, wdata, byte enables and op, loads the counter with LATENCY-1, and moves to WAIT. Otherwise it stays in IDLE.
  - WAIT: the counter decrements each cycle. When the counter is 0, the FSM performs the access at the edge and moves to RESP.
  - RESP: mem_resp=1 for exactly one cycle, then unconditional return to IDLE.
- Latency: a request accepted at edge k gives mem_resp high in the cycle after edge k+LATENCY. With LATENCY=1, mem_resp is high in the second cycle after the request first appears in IDLE.
- Back-to-back requests: the earliest next request is sampled in the IDLE cycle that follows RESP. The initiator must deassert in the cycle after mem_resp or it issues a new request.
- The request inputs are not rechecked during WAIT. The latched copy is authoritative.
- Address mapping:
  - word index = (mem_address - BASE_ADDR) >> 2, using 32-bit unsigned subtraction.
  - mem_address[1:0] is ignored.
  - The address is in range if the difference is below 4*2^DEPTH_LOG2. Addresses below BASE_ADDR wrap to large values and are out of range.
- Read: mem_rdata takes the array word when moving to RESP and holds that value until the next read completes. Writes do not disturb mem_rdata.
- Write: only enabled byte lanes are updated. mem_byte_enable=0 is a legal no-op and still produces mem_resp.
- Errors: all of the following give mem_resp plus mem_err, with no array change.
  - Out-of-range read: mem_rdata=32'hDEADBEEF.
  - Out-of-range write: write dropped.
  - mem_read and mem_write both high at acceptance: treated as an error and no access is performed.
- Preload:
  - init_we writes init_data at init_addr at the edge in any state.
  - If a bus write commits the same word at the same edge, the bus write wins on its enabled lanes.
  - A preload to a word being read in the same edge returns the old contents.

Decomposition:
- Shared package (alongside rv32i_types):
  - responder state enum (IDLE/WAIT/RESP)
  - ERR_RDATA constant 32'hDEADBEEF
  - default BASE_ADDR constant
- One sub-module, mem_responder_array: a 2^DEPTH_LOG2 x 32 array with one byte-enabled write port, one preload write port and a synchronous read. The bus write has priority over the preload write.
- The FSM, counter, request latch and range check stay in the top module.

Test Plan:
- Preload word 0 = 32'h00000013, LATENCY=3. Hold mem_read with mem_address=32'h40000000. Expect mem_resp exactly 3 cycles after acceptance, mem_rdata=32'h00000013, mem_err=0, and a one-cycle pulse.
- Write 32'hAABBCCDD at 32'h40000010 with mem_byte_enable=4'b0101 over preloaded 32'h11223344, then read it back. Expect 32'h11BB33DD.
- Back-to-back: read, deassert for 1 cycle, then read the next word. Expect two mem_resp pulses 5 cycles apart with LATENCY=3, and each mem_rdata correct.
- Read at 32'h3FFFFFFC and at BASE_ADDR+4096. Expect mem_resp plus mem_err, mem_rdata=32'hDEADBEEF. A write to 32'h3FFFFFFC leaves the array unchanged.
- mem_read=mem_write=1 at 32'h40000000 with mem_wdata=0, mem_byte_enable=4'hF. Expect mem_resp plus mem_err, with a readback still equal to the preloaded value.
- Drive rst=0 mid-WAIT of a write to word 2, then release. Expect no mem_resp, mem_rdata=0, word 2 unchanged and the FSM in IDLE. A subsequent read of word 2 completes normally.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and constants for the memory responder
package mem_responder_pkg;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_WAIT = 2'd1,
    RESP_RESP = 2'd2
  } resp_state_e;

  localparam logic [31:0] ERR_RDATA         = 32'hDEADBEEF;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h40000000;

endpackage

// File: rtl/mem_responder_array.sv
// rtl/mem_responder_array.sv - word array with byte-enabled bus write, preload write, sync read
module mem_responder_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  input  logic                  init_we,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [31:0]           init_data,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // Bus lanes are assigned after the preload so they win on a same-word collision.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency memory bus target with preload port
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 3,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [3:0]            mem_byte_enable,
  input  logic [31:0]           mem_address,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_resp,
  output logic                  mem_err,
  input  logic                  init_we,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [31:0]           init_data
);

  localparam logic [1:0] IDLE = RESP_IDLE;
  localparam logic [1:0] WAIT = RESP_WAIT;
  localparam logic [1:0] RESP = RESP_RESP;

  localparam int          CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] SPAN  = 33'(4) << DEPTH_LOG2;

  // Source of mem_rdata: cleared by reset, last array read, or error pattern.
  localparam logic [1:0] RSEL_ZERO = 2'd0;
  localparam logic [1:0] RSEL_ARR  = 2'd1;
  localparam logic [1:0] RSEL_ERR  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             op_rd;
  logic             op_wr;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic             err_q;
  logic [1:0]       rsel;

  logic [31:0]           offset;
  logic                  in_range;
  logic                  access;
  logic                  conflict;
  logic                  arr_we;
  logic                  arr_re;
  logic [31:0]           arr_rdata;
  logic [DEPTH_LOG2-1:0] widx;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = ({1'b0, offset} < SPAN);
  assign widx     = offset[DEPTH_LOG2+1:2];
  assign conflict = op_rd & op_wr;
  assign access   = (state == WAIT) && (cnt == '0);
  assign arr_we   = access && op_wr && !conflict && in_range;
  assign arr_re   = access && op_rd && !conflict && in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_rd   <= 1'b0;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      rsel    <= RSEL_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            op_rd   <= mem_read;
            op_wr   <= mem_write;
            addr_q  <= mem_address;
            wdata_q <= mem_wdata;
            be_q    <= mem_byte_enable;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            err_q <= conflict || !in_range;
            if (op_rd && !conflict) begin
              rsel <= in_range ? RSEL_ARR : RSEL_ERR;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rdata = '0;
    case (rsel)
      RSEL_ARR: mem_rdata = arr_rdata;
      RSEL_ERR: mem_rdata = ERR_RDATA;
      default:  mem_rdata = '0;
    endcase
  end

  assign mem_resp = (state == RESP);
  assign mem_err  = mem_resp & err_q;

  mem_responder_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk       (clk),
    .we        (arr_we),
    .re        (arr_re),
    .addr      (widx),
    .be        (be_q),
    .wdata     (wdata_q),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .rdata     (arr_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized and directed bench with behavioural memory model
module tb_mem_responder;

  localparam int          DL2   = 10;
  localparam int          LAT   = 3;
  localparam int          WORDS = 1 << DL2;
  localparam logic [31:0] BASE  = 32'h40000000;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           mem_read = 1'b0;
  logic           mem_write = 1'b0;
  logic [3:0]     mem_byte_enable = '0;
  logic [31:0]    mem_address = '0;
  logic [31:0]    mem_wdata = '0;
  logic [31:0]    mem_rdata;
  logic           mem_resp;
  logic           mem_err;
  logic           init_we = 1'b0;
  logic [DL2-1:0] init_addr = '0;
  logic [31:0]    init_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit noise_on = 1'b0;

  always #5 clk = ~clk;

  mem_responder #(
    .DEPTH_LOG2(DL2),
    .LATENCY   (LAT),
    .BASE_ADDR (BASE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .mem_err         (mem_err),
    .init_we         (init_we),
    .init_addr       (init_addr),
    .init_data       (init_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Behavioural model: a transaction accepted at edge e completes at edge e+LAT,
  // responds in the following cycle, and the responder listens again one edge later.
  logic [31:0] mdl_mem [WORDS];
  logic [31:0] ex_rdata = '0;
  logic        ex_resp = 1'b0;
  logic        ex_err = 1'b0;

  initial begin
    int          edge_n;
    int          acc;
    bit          pend;
    bit          t_rd, t_wr, do_wr;
    logic [31:0] t_addr, t_wd, off;
    logic [3:0]  t_be;
    edge_n = 0; acc = 0; pend = 0;
    t_rd = 0; t_wr = 0; t_addr = '0; t_wd = '0; t_be = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        pend = 0; ex_resp = 0; ex_err = 0; ex_rdata = '0;
        if (clk && init_we) mdl_mem[init_addr] = init_data;
      end else begin
        do_wr = 0;
        off = '0;
        ex_resp = 0;
        ex_err = 0;
        if (pend && edge_n == acc + LAT + 1) begin
          pend = 0;
        end else if (pend && edge_n == acc + LAT) begin
          off = t_addr - BASE;
          ex_resp = 1;
          if (t_rd && t_wr) begin
            ex_err = 1;
          end else if (off >= 32'(4 * WORDS)) begin
            ex_err = 1;
            if (t_rd) ex_rdata = 32'hDEADBEEF;
          end else if (t_rd) begin
            ex_rdata = mdl_mem[off / 4];
          end else begin
            do_wr = 1;
          end
        end else if (!pend && (mem_read || mem_write)) begin
          pend = 1; acc = edge_n;
          t_rd = mem_read; t_wr = mem_write;
          t_addr = mem_address; t_wd = mem_wdata; t_be = mem_byte_enable;
        end
        if (init_we) mdl_mem[init_addr] = init_data;
        if (do_wr) begin
          for (int b = 0; b < 4; b++)
            if (t_be[b]) mdl_mem[off / 4][8*b +: 8] = t_wd[8*b +: 8];
        end
        edge_n++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("model_resp", {31'b0, mem_resp}, {31'b0, ex_resp});
      chk("model_err", {31'b0, mem_err}, {31'b0, ex_err});
      chk("model_rdata", mem_rdata, ex_rdata);
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int rcyc);
    int n;
    n = 0; rdata = '0; err = 1'b0; lat = -1; rcyc = -1;
    @(negedge clk); #2;
    mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = wd; mem_byte_enable = be;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (mem_resp) begin
        rdata = mem_rdata; err = mem_err; lat = n; rcyc = cyc;
        break;
      end
    end
    #2;
    mem_read = 1'b0; mem_write = 1'b0;
    if (lat < 0) chk("resp_timeout", 32'(lat), 32'(LAT + 1));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, rc, rc2, seen;
    logic [31:0] a;
    int          r, sel;

    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_resp", {31'b0, mem_resp}, 32'h0);
    chk("reset_err", {31'b0, mem_err}, 32'h0);
    chk("reset_rdata", mem_rdata, 32'h0);

    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk); #2;
      init_we = 1'b1; init_addr = DL2'(i);
      case (i)
        0:       init_data = 32'h00000013;
        1:       init_data = 32'h00500093;
        2:       init_data = 32'h0000A5A5;
        4:       init_data = 32'h11223344;
        1023:    init_data = 32'hCAFE0FF3;
        default: init_data = $urandom;
      endcase
    end
    @(negedge clk); #2 init_we = 1'b0;

    do_req(1, 0, BASE, 0, 0, rd, er, lat, rc);
    chk("read0_data", rd, 32'h00000013);
    chk("read0_err", {31'b0, er}, 32'h0);
    chk("read0_latency", 32'(lat - 1), 32'd3);
    @(negedge clk);
    chk("read0_pulse", {31'b0, mem_resp}, 32'h0);

    do_req(0, 1, 32'h40000010, 32'hAABBCCDD, 4'b0101, rd, er, lat, rc);
    chk("bytewr_err", {31'b0, er}, 32'h0);
    do_req(1, 0, 32'h40000010, 0, 0, rd, er, lat, rc);
    chk("bytewr_readback", rd, 32'h11BB33DD);

    do_req(1, 0, BASE, 0, 0, rd, er, lat, rc);
    chk("b2b_first", rd, 32'h00000013);
    do_req(1, 0, BASE + 4, 0, 0, rd, er, lat, rc2);
    chk("b2b_second", rd, 32'h00500093);
    chk("b2b_spacing", 32'(rc2 - rc), 32'd5);

    do_req(1, 0, 32'h3FFFFFFC, 0, 0, rd, er, lat, rc);
    chk("oob_low_err", {31'b0, er}, 32'h1);
    chk("oob_low_data", rd, 32'hDEADBEEF);
    do_req(1, 0, BASE + 4096, 0, 0, rd, er, lat, rc);
    chk("oob_high_err", {31'b0, er}, 32'h1);
    chk("oob_high_data", rd, 32'hDEADBEEF);
    do_req(0, 1, 32'h3FFFFFFC, 32'h0BADF00D, 4'hF, rd, er, lat, rc);
    chk("oob_wr_err", {31'b0, er}, 32'h1);
    do_req(1, 0, BASE + 4092, 0, 0, rd, er, lat, rc);
    chk("oob_wr_no_alias", rd, 32'hCAFE0FF3);

    do_req(1, 1, BASE, 0, 4'hF, rd, er, lat, rc);
    chk("both_err", {31'b0, er}, 32'h1);
    do_req(1, 0, BASE, 0, 0, rd, er, lat, rc);
    chk("both_no_write", rd, 32'h00000013);

    @(negedge clk); #2;
    mem_write = 1'b1; mem_address = BASE + 8; mem_wdata = 32'hFFFFFFFF; mem_byte_enable = 4'hF;
    @(negedge clk); @(negedge clk); #2;
    rst = 1'b0; mem_write = 1'b0;
    #1;
    chk("rst_resp", {31'b0, mem_resp}, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_resp) seen++;
    end
    chk("rst_no_resp", 32'(seen), 32'h0);
    do_req(1, 0, BASE + 8, 0, 0, rd, er, lat, rc);
    chk("rst_word2_kept", rd, 32'h0000A5A5);
    chk("rst_then_latency", 32'(lat - 1), 32'd3);

    noise_on = 1'b1;
    fork
      begin
        for (int t = 0; t < 300; t++) begin
          r = $urandom_range(0, 19);
          sel = $urandom_range(0, 9);
          if (sel < 7)       a = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
          else if (sel == 7) a = BASE + 32'(4 * $urandom_range(1020, 1027));
          else if (sel == 8) a = BASE - 32'(4 * $urandom_range(1, 4));
          else               a = $urandom;
          do_req(r < 9 || r >= 17, r >= 9, a, $urandom, 4'($urandom), rd, er, lat, rc);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        noise_on = 1'b0;
      end
      begin
        while (noise_on) begin
          @(negedge clk); #2;
          init_we = ($urandom_range(0, 4) == 0);
          init_addr = DL2'($urandom_range(0, 15));
          init_data = $urandom;
        end
        init_we = 1'b0;
      end
    join

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
